// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_pkg: shared types and defaults for the counter sequencing
// controller.
//   state_t         : FSM encoding (IDLE=0, LOAD=1, RUN=2, SHOW=3, DONE=4)
//   HOLD_CYCLES_DEF : default number of cycles ctr_oe is held in SHOW
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    SHOW = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int unsigned HOLD_CYCLES_DEF = 4;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: request/strobe bundle between the requesters, the
// sequencing controller and the shared counter.
//   req, preset0, preset1, run_len           : requester side -> controller
//   gnt, done, busy                          : controller -> requesters
//   ctr_load, ctr_load_val, ctr_en, ctr_oe   : controller -> counter
// modport master is the requester/counter side, modport slave the controller.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) ();

  logic [1:0]       req;
  logic [WIDTH-1:0] preset0;
  logic [WIDTH-1:0] preset1;
  logic [LEN_W-1:0] run_len;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic             ctr_load;
  logic [WIDTH-1:0] ctr_load_val;
  logic             ctr_en;
  logic             ctr_oe;

  modport master (
    output req, preset0, preset1, run_len,
    input  gnt, done, busy, ctr_load, ctr_load_val, ctr_en, ctr_oe
  );

  modport slave (
    input  req, preset0, preset1, run_len,
    output gnt, done, busy, ctr_load, ctr_load_val, ctr_en, ctr_oe
  );

endinterface

// File: rtl/counter_seq_ctrl_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin pick.
//   req    : request bits
//   last   : index of the previous winner
//   gnt_oh : one-hot winner (all zero when no request)
// On a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt_oh
);

  always_comb begin
    gnt_oh = '0;
    case (req)
      2'b01:   gnt_oh = 2'b01;
      2'b10:   gnt_oh = 2'b10;
      2'b11:   gnt_oh = last ? 2'b01 : 2'b10;
      default: gnt_oh = '0;
    endcase
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: round-robin sequencing controller for a shared loadable
// counter. A granted requester gets LOAD -> RUN (len_q cycles of ctr_en) ->
// SHOW (HOLD_CYCLES cycles of ctr_oe) -> DONE (one-cycle done pulse).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : counter_seq_ctrl_if slave modport (requests, presets,
//                run length in; grant, done, busy and counter strobes out)
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int LEN_W       = 4,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input logic               clk,
  input logic               rst_n,
  counter_seq_ctrl_if.slave bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int CNT_W  = (LEN_W > HOLD_W) ? LEN_W : HOLD_W;

  state_t           state;
  logic             last;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic [1:0]       win_oh;

  rr_arb2 u_arb (
    .req    (bus.req),
    .last   (last),
    .gnt_oh (pick)
  );

  // last doubles as the current winner: it is written on entry to LOAD and
  // cannot change again before the next IDLE.
  assign win_oh = last ? 2'b10 : 2'b01;

  // cnt holds the remaining cycles of the current RUN/SHOW phase minus one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      len_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state <= LOAD;
            last  <= pick[1];
            len_q <= bus.run_len;
          end
        end
        LOAD: begin
          if (len_q != '0) begin
            state <= RUN;
            cnt   <= CNT_W'(len_q) - CNT_W'(1);
          end else begin
            state <= SHOW;
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state <= SHOW;
            cnt   <= CNT_W'(HOLD_CYCLES - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are a registered decode of the current state, so they trail the
  // state register by one cycle: a request sampled at edge N shows gnt and
  // ctr_load after edge N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.busy         <= 1'b0;
      bus.gnt          <= '0;
      bus.done         <= '0;
      bus.ctr_load     <= 1'b0;
      bus.ctr_load_val <= '0;
      bus.ctr_en       <= 1'b0;
      bus.ctr_oe       <= 1'b0;
    end else begin
      bus.busy         <= (state != IDLE);
      bus.gnt          <= (state != IDLE) ? win_oh : 2'b00;
      bus.done         <= (state == DONE) ? win_oh : 2'b00;
      bus.ctr_load     <= (state == LOAD);
      bus.ctr_load_val <= (state == LOAD) ? (last ? bus.preset1 : bus.preset0) : '0;
      bus.ctr_en       <= (state == RUN);
      bus.ctr_oe       <= (state == SHOW);
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed self-checking bench for counter_seq_ctrl.
// Includes a reference model of the shared counter driven by the strobes.
module tb_counter_seq_ctrl;

  logic clk;
  logic rst_n;

  counter_seq_ctrl_if #(.WIDTH(8), .LEN_W(4)) bus ();

  counter_seq_ctrl #(.WIDTH(8), .LEN_W(4), .HOLD_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared counter: load has priority, otherwise increment when enabled
  logic [7:0] mdl_ctr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              mdl_ctr <= 8'h00;
    else if (bus.ctr_load)   mdl_ctr <= bus.ctr_load_val;
    else if (bus.ctr_en)     mdl_ctr <= mdl_ctr + 8'h01;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // per-sequence measurements
  int         m_lat, m_busy, m_load, m_en, m_oe, m_done, m_oe_start, m_ovl, m_gnt_bad, m_lv_bad;
  logic [1:0] m_gnt, m_done_v;
  logic [7:0] m_lval, m_ctr_show;

  // Waits for busy, then walks the sequence cycle by cycle. Requester
  // behaviour hooks: set_in_run raised during RUN, clr_in_show dropped during
  // SHOW, drop_mask cleared when done pulses, run_len rewritten during RUN.
  task automatic measure(input logic [1:0] drop_mask, input logic [1:0] set_in_run,
                         input logic [1:0] clr_in_show, input bit chg_len,
                         input logic [3:0] new_len);
    int t;
    m_lat = 0; m_busy = 0; m_load = 0; m_en = 0; m_oe = 0; m_done = 0;
    m_oe_start = -1; m_ovl = 0; m_gnt_bad = 0; m_lv_bad = 0;
    m_gnt = '0; m_done_v = '0; m_lval = '0; m_ctr_show = '0;
    while (!bus.busy && m_lat < 20) begin
      tick();
      m_lat++;
    end
    t = 0;
    while (bus.busy && t < 64) begin
      if (t == 0) m_gnt = bus.gnt;
      else if (bus.gnt !== m_gnt) m_gnt_bad++;
      if (bus.ctr_load) begin
        m_load++;
        m_lval = bus.ctr_load_val;
      end else if (bus.ctr_load_val != 8'h00) m_lv_bad++;
      if (bus.ctr_en) begin
        m_en++;
        bus.req = bus.req | set_in_run;
        if (chg_len) bus.run_len = new_len;
      end
      if (bus.ctr_oe) begin
        if (m_oe == 0) begin
          m_oe_start = t;
          m_ctr_show = mdl_ctr;
        end
        m_oe++;
        bus.req = bus.req & ~clr_in_show;
      end
      if (bus.done != 2'b00) begin
        m_done++;
        m_done_v = bus.done;
        bus.req = bus.req & ~drop_mask;
      end
      if (bus.ctr_en && (bus.ctr_load || bus.ctr_oe)) m_ovl++;
      m_busy++;
      tick();
      t++;
    end
  endtask

  function automatic logic [15:0] all_outs();
    return {bus.busy, bus.gnt, bus.done, bus.ctr_load, bus.ctr_load_val, bus.ctr_en, bus.ctr_oe};
  endfunction

  initial begin
    int k;
    int t;
    rst_n = 1'b0;
    bus.req = 2'b00; bus.preset0 = 8'h00; bus.preset1 = 8'h00; bus.run_len = 4'd0;
    repeat (2) tick();
    chk("reset_outs", all_outs(), 16'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_outs", all_outs(), 16'h0);

    // single request with counter wrap: 0xFD + 4 = 0x01
    bus.preset0 = 8'hFD; bus.run_len = 4'd4; bus.req = 2'b01;
    measure(2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
    chk("single_lat", m_lat, 2);
    chk("single_gnt", m_gnt, 2'b01);
    chk("single_load_n", m_load, 1);
    chk("single_load_val", m_lval, 8'hFD);
    chk("single_en_n", m_en, 4);
    chk("single_oe_n", m_oe, 4);
    chk("single_oe_start", m_oe_start, 5);
    chk("single_ctr", m_ctr_show, 8'h01);
    chk("single_done_n", m_done, 1);
    chk("single_done_v", m_done_v, 2'b01);
    chk("single_busy_n", m_busy, 10);
    chk("single_overlap", m_ovl, 0);
    chk("single_gnt_hold", m_gnt_bad, 0);
    chk("single_lval_zero", m_lv_bad, 0);
    tick();
    chk("single_no_regrant", all_outs(), 16'h0);

    // zero length: RUN skipped, counter keeps preset
    bus.preset1 = 8'h42; bus.run_len = 4'd0; bus.req = 2'b10;
    measure(2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
    chk("zero_gnt", m_gnt, 2'b10);
    chk("zero_load_val", m_lval, 8'h42);
    chk("zero_en_n", m_en, 0);
    chk("zero_oe_start", m_oe_start, 1);
    chk("zero_ctr", m_ctr_show, 8'h42);
    chk("zero_busy_n", m_busy, 6);
    chk("zero_done_v", m_done_v, 2'b10);
    tick();

    // tie fairness: both held high, grants alternate starting with 0
    bus.preset0 = 8'h01; bus.preset1 = 8'h02; bus.run_len = 4'd1; bus.req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      measure((i == 3) ? 2'b11 : 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
      chk($sformatf("tie_gnt%0d", i), m_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("tie_lat%0d", i), m_lat, (i == 0) ? 2 : 1);
      chk($sformatf("tie_busy%0d", i), m_busy, 7);
    end
    tick();
    chk("tie_idle_after", bus.busy, 1'b0);

    // request drop during SHOW and late request during RUN
    bus.preset0 = 8'h20; bus.preset1 = 8'h80; bus.run_len = 4'd2; bus.req = 2'b01;
    measure(2'b00, 2'b10, 2'b01, 1'b0, 4'd0);
    chk("drop_gnt", m_gnt, 2'b01);
    chk("drop_done_v", m_done_v, 2'b01);
    chk("drop_ctr", m_ctr_show, 8'h22);
    chk("drop_req_state", bus.req, 2'b10);
    measure(2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
    chk("late_lat", m_lat, 1);
    chk("late_gnt", m_gnt, 2'b10);
    chk("late_ctr", m_ctr_show, 8'h82);
    tick();

    // run_len rewritten during RUN has no effect
    bus.run_len = 4'd3; bus.req = 2'b01;
    measure(2'b11, 2'b00, 2'b00, 1'b1, 4'd9);
    chk("sample_en_n", m_en, 3);
    chk("sample_ctr", m_ctr_show, 8'h23);
    chk("sample_busy_n", m_busy, 9);
    tick();

    // reset on the 3rd RUN cycle
    bus.preset0 = 8'h10; bus.run_len = 4'd5; bus.req = 2'b01;
    k = 0; t = 0;
    while (k < 3 && t < 30) begin
      tick();
      t++;
      if (bus.ctr_en) k++;
    end
    chk("rst_reach_run", k, 3);
    bus.req = 2'b00;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), 16'h0);
    chk("rst_ctr_model", mdl_ctr, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_release_idle", all_outs(), 16'h0);
    tick();
    chk("rst_stay_idle", bus.busy, 1'b0);
    bus.req = 2'b11; bus.run_len = 4'd1;
    measure(2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
    chk("rst_tie_gnt", m_gnt, 2'b01);
    chk("rst_tie_lat", m_lat, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
